// File: rtl/disk_pkg.sv
// Shared encodings for the disk arbiter: command ops, instruction word
// layout, buffer-write word and the ownership/operation state machine.
package disk_pkg;

    localparam int N_REQ    = 2;
    localparam int SECTOR_W = 29;
    localparam int ADDR_W   = 9;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        OP_BUF_WR  = 2'd0,
        OP_DISK_RD = 2'd1,
        OP_DISK_WR = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    localparam int INSTR_SEL  = 31;
    localparam int INSTR_WR   = 30;
    localparam int INSTR_UART = 29;

    localparam logic [WORD_W-1:0] BUF_WR_WORD = 32'hC000_0000;

    typedef enum logic [2:0] {
        FREE  = 3'd0,
        OWNED = 3'd1,
        BUF   = 3'd2,
        ISSUE = 3'd3,
        BUSY  = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Device instruction for a UART-backed sector transfer.
    function automatic logic [WORD_W-1:0] disk_word(input op_e op,
                                                    input logic [SECTOR_W-1:0] sector);
        logic [WORD_W-1:0] w;
        w                 = '0;
        w[INSTR_SEL]      = 1'b1;
        w[INSTR_WR]       = (op == OP_DISK_WR);
        w[INSTR_UART]     = 1'b1;
        w[SECTOR_W-1:0]   = sector;
        return w;
    endfunction

endpackage

// File: rtl/disk_arbiter_if.sv
// Requester-side bus of the disk arbiter; lane i of every vector belongs to
// requester i (0 = CPU MMIO, 1 = boot loader).
interface disk_arbiter_if;
    import disk_pkg::*;

    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0]          gnt;
    logic [N_REQ-1:0]          cmd_valid;
    logic [2*N_REQ-1:0]        cmd_op;
    logic [SECTOR_W*N_REQ-1:0] cmd_sector;
    logic                      cmd_ready;
    logic [ADDR_W*N_REQ-1:0]   buf_addr;
    logic [WORD_W*N_REQ-1:0]   buf_wdata;
    logic [WORD_W*N_REQ-1:0]   buf_rdata;
    logic [N_REQ-1:0]          rsp_valid;
    logic [N_REQ-1:0]          rsp_err;

    modport master (
        output req, cmd_valid, cmd_op, cmd_sector, buf_addr, buf_wdata,
        input  gnt, cmd_ready, buf_rdata, rsp_valid, rsp_err
    );

    modport slave (
        input  req, cmd_valid, cmd_op, cmd_sector, buf_addr, buf_wdata,
        output gnt, cmd_ready, buf_rdata, rsp_valid, rsp_err
    );

endinterface

// File: rtl/disk_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not own the
// device last time wins; otherwise the single requester is picked.
module disk_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] pick
);

    // One-hot pick from the current request vector.
    always_comb begin
        pick = 2'b00;
        if (req == 2'b11) begin
            pick = last_owner ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule

// File: rtl/disk_arbiter.sv
// Grants the single sector disk device to one of two requesters, converts
// owner commands into device instruction words and read/write start pulses,
// waits for completion with a timeout and routes buffer word accesses.
module disk_arbiter
    import disk_pkg::*;
#(
    parameter int TO_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    disk_arbiter_if.slave       req_if,
    output logic [WORD_W-1:0]   dev_instruction,
    output logic [ADDR_W-1:0]   dev_addr,
    output logic [WORD_W-1:0]   dev_data_in,
    input  logic [WORD_W-1:0]   dev_data_out,
    output logic                dev_read_pause,
    output logic                dev_write_pause,
    input  logic                dev_operate_done
);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [TO_W-1:0]       timer_q, timer_d;
    logic                  err_q, err_d;
    op_e                   op_q, op_d;
    logic [SECTOR_W-1:0]   sector_q, sector_d;

    logic [1:0]            pick;
    logic                  own_req;
    logic                  own_valid;
    op_e                   own_op;
    logic [SECTOR_W-1:0]   own_sector;
    logic [ADDR_W-1:0]     own_addr;
    logic [WORD_W-1:0]     own_wdata;
    logic                  owned;

    disk_rr_pick u_pick (
        .req        (req_if.req),
        .last_owner (last_owner_q),
        .pick       (pick)
    );

    // Select the current owner's lane of every requester input.
    always_comb begin
        own_req    = req_if.req[owner_q];
        own_valid  = req_if.cmd_valid[owner_q];
        own_op     = op_e'(owner_q ? req_if.cmd_op[3:2] : req_if.cmd_op[1:0]);
        own_sector = owner_q ? req_if.cmd_sector[2*SECTOR_W-1:SECTOR_W]
                             : req_if.cmd_sector[SECTOR_W-1:0];
        own_addr   = owner_q ? req_if.buf_addr[2*ADDR_W-1:ADDR_W]
                             : req_if.buf_addr[ADDR_W-1:0];
        own_wdata  = owner_q ? req_if.buf_wdata[2*WORD_W-1:WORD_W]
                             : req_if.buf_wdata[WORD_W-1:0];
    end

    // Ownership and operation sequencing; done beats timeout in the same cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        timer_d      = timer_q;
        err_d        = err_q;
        op_d         = op_q;
        sector_d     = sector_q;
        case (state_q)
            FREE: begin
                if (|req_if.req) begin
                    state_d      = OWNED;
                    owner_d      = pick[1];
                    last_owner_d = pick[1];
                end
            end
            OWNED: begin
                if (!own_req) begin
                    state_d = FREE;
                end else if (own_valid) begin
                    op_d     = own_op;
                    sector_d = own_sector;
                    err_d    = 1'b0;
                    case (own_op)
                        OP_BUF_WR:  state_d = BUF;
                        OP_DISK_RD: state_d = ISSUE;
                        OP_DISK_WR: state_d = ISSUE;
                        default: begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            BUF: begin
                state_d = DONE;
            end
            ISSUE: begin
                timer_d = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (dev_operate_done) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == {TO_W{1'b1}}) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = OWNED;
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FREE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            timer_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
        end
    end

    // Latched command so the requester may change its inputs after acceptance.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        sector_q <= sector_d;
    end

    // Requester-facing and device-facing outputs decoded from the state.
    always_comb begin
        owned              = (state_q != FREE);
        req_if.gnt         = owned ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        req_if.cmd_ready   = (state_q == OWNED);
        req_if.rsp_valid   = 2'b00;
        req_if.rsp_err     = 2'b00;
        if (state_q == DONE) begin
            req_if.rsp_valid[owner_q] = 1'b1;
            req_if.rsp_err[owner_q]   = err_q;
        end
        req_if.buf_rdata   = '0;
        if (owned) begin
            if (owner_q) begin
                req_if.buf_rdata[2*WORD_W-1:WORD_W] = dev_data_out;
            end else begin
                req_if.buf_rdata[WORD_W-1:0] = dev_data_out;
            end
        end
        dev_addr        = owned ? own_addr : '0;
        dev_data_in     = owned ? own_wdata : '0;
        dev_read_pause  = (state_q == ISSUE) && (op_q == OP_DISK_RD);
        dev_write_pause = (state_q == ISSUE) && (op_q == OP_DISK_WR);
        dev_instruction = '0;
        case (state_q)
            BUF:   dev_instruction = BUF_WR_WORD;
            ISSUE: dev_instruction = disk_word(op_q, sector_q);
            BUSY:  dev_instruction = disk_word(op_q, sector_q);
            DONE: begin
                if ((op_q == OP_DISK_RD) || (op_q == OP_DISK_WR)) begin
                    dev_instruction = disk_word(op_q, sector_q);
                end
            end
            default: dev_instruction = '0;
        endcase
    end

endmodule

// File: doc/disk_arbiter.md
# disk_arbiter

Shares the single UART-backed sector disk device between two requesters: requester 0 is the CPU MMIO port and requester 1 is the boot loader. The block grants exclusive ownership round-robin and turns owner commands into the device's instruction word and one-cycle read/write pause pulses. It holds the instruction stable until the device reports completion and enforces a completion timeout. It also routes the owner's 512-byte buffer word accesses to the device.

## Interface
Parameters:
- TO_W, 24: timeout counter width. A disk operation times out after 2^TO_W − 1 cycles in BUSY.

Ports (packed vectors; index i is requester i):
- clk  in  1  system clock. One clock domain; everything is registered on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- req  in  2  level ownership request.
- gnt  out  2  one-hot owner (00 when there is no owner).
- cmd_valid  in  2  command strobe from requester i.
- cmd_op  in  4  2 bits per requester: 0 BUF_WR, 1 DISK_RD, 2 DISK_WR (3 is reserved and completes with an error).
- cmd_sector  in  58  29 bits per requester: the sector number.
- cmd_ready  out  1  high when the owner may issue a command.
- buf_addr  in  18  9 bits per requester: byte address with [1:0]=0.
- buf_wdata  in  64  32 bits per requester.
- buf_rdata  out  64  dev_data_out for the owner lane; 0 on the other lane.
- rsp_valid  out  2  one-cycle completion pulse to requester i.
- rsp_err  out  2  qualifies rsp_valid: timeout or reserved op.
- dev_instruction  out  32  to the device instruction input.
- dev_addr  out  9  owner's buf_addr; 0 when there is no owner.
- dev_data_in  out  32  owner's buf_wdata.
- dev_data_out  in  32  device buffer read data.
- dev_read_pause  out  1  one-cycle read start pulse.
- dev_write_pause  out  1  one-cycle write start pulse.
- dev_operate_done  in  1  device completion.

## Operation
- Instruction word layout:
  - bit31 = device select.
  - bit30 = write (1) / read (0).
  - bit29 = UART op (1) / buffer access (0).
  - [28:0] = sector.
  - dev_instruction is 0 in FREE and OWNED.
- States:
  - FREE: gnt=00. If any req is set, grant it, choosing the requester other than last_owner when both request. Move to OWNED.
  - OWNED: cmd_ready=1. If the owner's req is low, go to FREE (gnt cleared next cycle). Otherwise, on cmd_valid[owner]:
    - BUF_WR → BUF.
    - DISK_RD or DISK_WR → ISSUE.
    - reserved op → DONE with err=1.
    - cmd_valid from the non-owner is ignored.
  - BUF: dev_instruction=0xC000_0000 for one cycle; the device writes the four bytes at dev_addr. Go to DONE.
  - ISSUE: dev_instruction={1, op==DISK_WR, 1, sector}. Assert exactly one of the pauses for this cycle only. Clear the timer. Go to BUSY.
  - BUSY: hold dev_instruction. On dev_operate_done go to DONE (err=0). If the timer reaches all-ones, go to DONE with err=1.
  - DONE: rsp_valid[owner]=1 and rsp_err per the cause. dev_instruction is still held this cycle. Go to OWNED.
- The command (op, sector) is latched at acceptance, so requester inputs may change afterward.
- Buffer reads are combinational: buf_rdata[owner] = dev_data_out for the current dev_addr. They are valid any cycle while gnt is held.
- last_owner updates when a grant is issued.

## Timing
- Reset values:
  - gnt=00, cmd_ready=0, rsp_valid=00, rsp_err=00.
  - dev_instruction=0, both pauses=0, timer=0.
  - last_owner=1, so requester 0 wins the first tie.
- Latencies:
  - req → gnt: 1 cycle.
  - BUF_WR acceptance → rsp_valid: 2 cycles.
  - DISK op acceptance → pause: 1 cycle. dev_operate_done → rsp_valid: 1 cycle.
- dev_operate_done is ignored during the ISSUE cycle; a stale pulse must not complete the op. It is sampled only in BUSY.
- If dev_operate_done and the timeout occur in the same cycle, done wins (err=0).
- If the owner drops req during BUF/ISSUE/BUSY/DONE, the operation completes and the response is still delivered. Release happens from OWNED.
- A timeout does not reset the device; the owner must assume device state is undefined.
- Reset asserted mid-operation returns to reset values on the next edge, and no response is emitted.
- A requester never holds ownership across an OWNED cycle with its req low.

## Structure
- disk_pkg holds:
  - the op encodings (BUF_WR, DISK_RD, DISK_WR);
  - the instruction bit positions (SEL=31, WR=30, UART=29);
  - the 0xC000_0000 buffer-write word;
  - the state enum (FREE, OWNED, BUF, ISSUE, BUSY, DONE).
- One sub-module, disk_rr_pick: a 2-way round-robin picker with inputs req[1:0] and last_owner and a one-hot output.

## Test plan
- After reset, assert req=11 → gnt=01 on the next cycle. Release 0 → FREE, then gnt=10 (round-robin).
- Owner 0 issues BUF_WR with addr=0x004, wdata=0xDEADBEEF → one cycle with dev_instruction=0xC000_0000 and dev_addr=0x004, then rsp_valid[0] with err=0. buf_rdata[0] reads 0xDEADBEEF.
- Owner issues DISK_RD with sector=5 → dev_instruction=0xA000_0005 and dev_read_pause high for exactly 1 cycle. The instruction is held until the model's dev_operate_done, then rsp_valid pulses once with err=0.
- DISK_WR with sector=0x1FFF_FFFF → dev_instruction=0xFFFF_FFFF and dev_write_pause pulses. Hold dev_operate_done high during the ISSUE cycle → it is ignored and the op stays in BUSY.
- TO_W=4 with no done → rsp_err=1 exactly 15 cycles after entering BUSY, then cmd_ready=1.
- The owner drops req during BUSY while the other requester is requesting → the response is still delivered, then FREE, then the other requester is granted. The non-owner's cmd_valid produces no device activity.
